// File: rtl/vga_timing_pkg.sv
// Shared constants, geometry helpers and sync bundle type for the VGA timing generator.
package vga_timing_pkg;

  // 640x480@60 raster with 25 MHz pixel clock derived from a 50 MHz board clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  // Sync/blank bundle carried through the output delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH x WIDTH shift register advancing on shift_en; DEPTH=0 is a pass-through.
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, rst, shift_en};
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

      // Next stage contents: move everything one slot along on shift_en
      always_comb begin
        stage_d = stage_q;
        if (shift_en) begin
          stage_d[0] = din;
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
      end

      // Stage registers, every slot reloaded with the inactive value on reset
      always_ff @(posedge clk) begin
        if (rst) stage_q <= {DEPTH{RST_VAL}};
        else     stage_q <= stage_d;
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel divider, x/y counters, raw sync and delayed sync/blank.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 1,
  localparam int  H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  X_W      = $clog2(H_TOTAL),
  localparam int  Y_W      = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic           vga_clk,
  output logic           pix_tick,
  output logic [X_W-1:0] x_pixel,
  output logic [Y_W-1:0] y_pixel,
  output logic           active,
  output logic           line_end,
  output logic           frame_done,
  output logic           hsync,
  output logic           vsync,
  output logic           blank_n,
  output logic           sync_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

  // Boundaries one bit wider than the counters so a zero back porch cannot overflow
  localparam logic [X_W:0] X_ACT_END  = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0] X_SYNC_BEG = (X_W+1)'(H_ACTIVE + H_FP);
  localparam logic [X_W:0] X_SYNC_END = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W:0] Y_ACT_END  = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0] Y_SYNC_BEG = (Y_W+1)'(V_ACTIVE + V_FP);
  localparam logic [Y_W:0] Y_SYNC_END = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0};

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             vga_clk_q, vga_clk_d;
  logic             pix_tick_q, pix_tick_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             active_q, active_d;
  logic             line_end_q, line_end_d;
  logic             frame_done_q, frame_done_d;
  vga_sync_t        raw_q, raw_d;
  vga_sync_t        dly_sync;
  logic             adv;
  logic             vga_clk_lvl;

  // The pixel advances on the clk whose divider count is the last of the period
  assign adv = en && (div_cnt_q == DIV_LAST);

  // DAC clock level from the upcoming divider count; tied low when clk is the pixel clock
  generate
    if (CLK_DIV > 1) begin : g_vclk
      localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
      assign vga_clk_lvl = (div_cnt_d >= DIV_HALF);
    end else begin : g_no_vclk
      assign vga_clk_lvl = 1'b0;
    end
  endgenerate

  // Divider, counters, event pulses and raw sync next-state
  always_comb begin
    div_cnt_d    = div_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    line_end_d   = 1'b0;
    frame_done_d = 1'b0;
    raw_d        = raw_q;

    if (en) div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;

    if (adv) begin
      if (x_q == X_LAST) begin
        x_d        = '0;
        line_end_d = 1'b1;
        if (y_q == Y_LAST) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    active_d   = ({1'b0, x_d} < X_ACT_END) && ({1'b0, y_d} < Y_ACT_END);
    vga_clk_d  = vga_clk_lvl;
    pix_tick_d = adv;

    // Raw sync/blank are sampled per pixel so blank stays low until the first tick after reset
    if (adv) begin
      raw_d.hs = (({1'b0, x_d} >= X_SYNC_BEG) && ({1'b0, x_d} < X_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      raw_d.vs = (({1'b0, y_d} >= Y_SYNC_BEG) && ({1'b0, y_d} < Y_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      raw_d.de = active_d;
    end
  end

  // State registers; reset restarts the raster at the visible origin
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      vga_clk_q    <= 1'b0;
      pix_tick_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      active_q     <= 1'b1;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      raw_q        <= SYNC_IDLE;
    end else begin
      div_cnt_q    <= div_cnt_d;
      vga_clk_q    <= vga_clk_d;
      pix_tick_q   <= pix_tick_d;
      x_q          <= x_d;
      y_q          <= y_d;
      active_q     <= active_d;
      line_end_q   <= line_end_d;
      frame_done_q <= frame_done_d;
      raw_q        <= raw_d;
    end
  end

  vga_delay_line #(
    .DEPTH   (PIPE_DLY),
    .WIDTH   ($bits(vga_sync_t)),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .shift_en (adv),
    .din      (raw_q),
    .dout     (dly_sync)
  );

  assign vga_clk    = vga_clk_q;
  assign pix_tick   = pix_tick_q;
  assign x_pixel    = x_q;
  assign y_pixel    = y_q;
  assign active     = active_q;
  assign line_end   = line_end_q;
  assign frame_done = frame_done_q;
  assign hsync      = dly_sync.hs;
  assign vsync      = dly_sync.vs;
  assign blank_n    = dly_sync.de;
  assign sync_n     = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: four timing generators on one clock (small raster, delayed, defaults, div-1 pos-pol).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // a: small raster, CLK_DIV=2, PIPE_DLY=0
  logic a_vclk, a_pt, a_act, a_le, a_fd, a_hs, a_vs, a_bn, a_sn;
  logic [2:0] a_x, a_y;
  // b: small raster, CLK_DIV=2, PIPE_DLY=3
  logic b_vclk, b_pt, b_act, b_le, b_fd, b_hs, b_vs, b_bn, b_sn;
  logic [2:0] b_x, b_y;
  // c: default 640x480 geometry
  logic c_vclk, c_pt, c_act, c_le, c_fd, c_hs, c_vs, c_bn, c_sn;
  logic [9:0] c_x, c_y;
  // d: small raster, CLK_DIV=1, SYNC_POL=1, PIPE_DLY=0
  logic d_vclk, d_pt, d_act, d_le, d_fd, d_hs, d_vs, d_bn, d_sn;
  logic [2:0] d_x, d_y;

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DLY(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .vga_clk(a_vclk), .pix_tick(a_pt), .x_pixel(a_x),
    .y_pixel(a_y), .active(a_act), .line_end(a_le), .frame_done(a_fd), .hsync(a_hs),
    .vsync(a_vs), .blank_n(a_bn), .sync_n(a_sn));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DLY(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .vga_clk(b_vclk), .pix_tick(b_pt), .x_pixel(b_x),
    .y_pixel(b_y), .active(b_act), .line_end(b_le), .frame_done(b_fd), .hsync(b_hs),
    .vsync(b_vs), .blank_n(b_bn), .sync_n(b_sn));

  vga_timing_gen u_c (
    .clk(clk), .rst(rst), .en(en), .vga_clk(c_vclk), .pix_tick(c_pt), .x_pixel(c_x),
    .y_pixel(c_y), .active(c_act), .line_end(c_le), .frame_done(c_fd), .hsync(c_hs),
    .vsync(c_vs), .blank_n(c_bn), .sync_n(c_sn));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(0)) u_d (
    .clk(clk), .rst(rst), .en(en), .vga_clk(d_vclk), .pix_tick(d_pt), .x_pixel(d_x),
    .y_pixel(d_y), .active(d_act), .line_end(d_le), .frame_done(d_fd), .hsync(d_hs),
    .vsync(d_vs), .blank_n(d_bn), .sync_n(d_sn));

  function automatic bit in_win(int v, int s, int w);
    return (v >= s) && (v < s + w);
  endfunction

  // Reference flags {pix_tick, vga_clk, line_end, frame_done, hsync, vsync, blank_n, active}
  // at clk c after reset release (c=0 is the reset state)
  function automatic logic [7:0] exp_flags(int c, int div, int dly, bit pol,
      int ha, int hf, int hw, int hb, int va, int vf, int vw, int vb);
    int ht = ha + hf + hw + hb;
    int vt = va + vf + vw + vb;
    int k = c / div;
    int j = k - dly;
    bit tick = (c % div == 0) && (c >= div);
    bit vga = (div > 1) && ((c % div) >= div / 2);
    bit le = tick && (k % ht == 0);
    bit fd = le && ((k / ht) % vt == 0);
    bit hs_on = (j >= 0) && in_win(j % ht, ha + hf, hw);
    bit vs_on = (j >= 0) && in_win((j / ht) % vt, va + vf, vw);
    bit de = (j >= 1) && (j % ht < ha) && ((j / ht) % vt < va);
    bit act = (k % ht < ha) && ((k / ht) % vt < va);
    return {tick, vga, le, fd, hs_on ? pol : ~pol, vs_on ? pol : ~pol, de, act};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) step();
    checks++;
    if ({a_x, a_y} !== 6'd0 || {a_pt, a_vclk, a_le, a_fd, a_hs, a_vs, a_bn, a_act, a_sn} !== 9'b000011010) begin
      failures++;
      $display("FAIL reset_a got x=%0d y=%0d flags=%b exp x=0 y=0 flags=000011010", a_x, a_y,
        {a_pt, a_vclk, a_le, a_fd, a_hs, a_vs, a_bn, a_act, a_sn});
    end
    checks++;
    if ({b_hs, b_vs, b_bn, b_sn} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_b got hs/vs/bn/sn=%b exp 1100", {b_hs, b_vs, b_bn, b_sn});
    end
    checks++;
    if ({c_x, c_y, c_pt, c_bn, c_hs, c_vs} !== {20'd0, 4'b0011}) begin
      failures++;
      $display("FAIL reset_c got x=%0d y=%0d pt/bn/hs/vs=%b exp 0 0 0011", c_x, c_y, {c_pt, c_bn, c_hs, c_vs});
    end
    checks++;
    if ({d_pt, d_vclk, d_hs, d_vs, d_bn} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_d got pt/vclk/hs/vs/bn=%b exp 00000", {d_pt, d_vclk, d_hs, d_vs, d_bn});
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_small_raster();
    int le_cnt = 0;
    int fd_cnt = 0;
    int fd_last = -1;
    int fd_gap = 0;
    logic [7:0] e;
    while (cyc < 200) begin
      step();
      e = exp_flags(cyc, 2, 0, 1'b0, 4, 1, 2, 1, 3, 1, 1, 1);
      checks++;
      if ({a_pt, a_vclk, a_le, a_fd, a_hs, a_vs, a_bn, a_act} !== e) begin
        failures++;
        $display("FAIL small_flags cyc=%0d got=%b exp=%b", cyc, {a_pt, a_vclk, a_le, a_fd, a_hs, a_vs, a_bn, a_act}, e);
      end
      checks++;
      if (int'(a_x) !== (cyc / 2) % 8 || int'(a_y) !== (cyc / 16) % 6) begin
        failures++;
        $display("FAIL small_xy cyc=%0d got x=%0d y=%0d exp x=%0d y=%0d", cyc, a_x, a_y, (cyc / 2) % 8, (cyc / 16) % 6);
      end
      if (a_le) le_cnt++;
      if (a_fd) begin
        fd_cnt++;
        if (fd_last >= 0) fd_gap = cyc - fd_last;
        fd_last = cyc;
      end
    end
    checks++;
    if (le_cnt !== 12) begin
      failures++;
      $display("FAIL small_line_end_count got=%0d exp=12", le_cnt);
    end
    checks++;
    if (fd_cnt !== 2 || fd_gap !== 96) begin
      failures++;
      $display("FAIL small_frame_period got count=%0d gap=%0d exp count=2 gap=96", fd_cnt, fd_gap);
    end
  endtask

  task automatic test_pipe_delay();
    logic [7:0] e;
    while (cyc < 400) begin
      step();
      e = exp_flags(cyc, 2, 3, 1'b0, 4, 1, 2, 1, 3, 1, 1, 1);
      checks++;
      if ({b_pt, b_vclk, b_le, b_fd, b_hs, b_vs, b_bn, b_act} !== e) begin
        failures++;
        $display("FAIL delay3_flags cyc=%0d got=%b exp=%b", cyc, {b_pt, b_vclk, b_le, b_fd, b_hs, b_vs, b_bn, b_act}, e);
      end
      checks++;
      if (int'(b_x) !== (cyc / 2) % 8 || int'(b_y) !== (cyc / 16) % 6) begin
        failures++;
        $display("FAIL delay3_xy cyc=%0d got x=%0d y=%0d exp x=%0d y=%0d", cyc, b_x, b_y, (cyc / 2) % 8, (cyc / 16) % 6);
      end
    end
  endtask

  task automatic test_pol_div1();
    int fd_cnt = 0;
    int fd_last = -1;
    int fd_gap = 0;
    logic [7:0] e;
    while (cyc < 600) begin
      step();
      e = exp_flags(cyc, 1, 0, 1'b1, 4, 1, 2, 1, 3, 1, 1, 1);
      checks++;
      if ({d_pt, d_vclk, d_le, d_fd, d_hs, d_vs, d_bn, d_act} !== e) begin
        failures++;
        $display("FAIL div1_flags cyc=%0d got=%b exp=%b", cyc, {d_pt, d_vclk, d_le, d_fd, d_hs, d_vs, d_bn, d_act}, e);
      end
      checks++;
      if (int'(d_x) !== cyc % 8 || int'(d_y) !== (cyc / 8) % 6) begin
        failures++;
        $display("FAIL div1_xy cyc=%0d got x=%0d y=%0d exp x=%0d y=%0d", cyc, d_x, d_y, cyc % 8, (cyc / 8) % 6);
      end
      if (d_fd) begin
        fd_cnt++;
        if (fd_last >= 0) fd_gap = cyc - fd_last;
        fd_last = cyc;
      end
    end
    checks++;
    if (fd_cnt !== 4 || fd_gap !== 48) begin
      failures++;
      $display("FAIL div1_frame_period got count=%0d gap=%0d exp count=4 gap=48", fd_cnt, fd_gap);
    end
  endtask

  task automatic test_defaults();
    int le_cnt = 0;
    int le_last = -1;
    int le_gap = 0;
    int hs_low = 0;
    logic [7:0] e;
    while (cyc < 4000) begin
      step();
      e = exp_flags(cyc, 2, 1, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33);
      checks++;
      if ({c_pt, c_vclk, c_le, c_fd, c_hs, c_vs, c_bn, c_act} !== e) begin
        failures++;
        $display("FAIL dflt_flags cyc=%0d got=%b exp=%b", cyc, {c_pt, c_vclk, c_le, c_fd, c_hs, c_vs, c_bn, c_act}, e);
      end
      checks++;
      if (int'(c_x) !== (cyc / 2) % 800 || int'(c_y) !== (cyc / 1600) % 525) begin
        failures++;
        $display("FAIL dflt_xy cyc=%0d got x=%0d y=%0d exp x=%0d y=%0d", cyc, c_x, c_y, (cyc / 2) % 800, (cyc / 1600) % 525);
      end
      if (c_le) begin
        le_cnt++;
        if (le_last >= 0) le_gap = cyc - le_last;
        le_last = cyc;
      end
      if (c_pt && !c_hs) hs_low++;
    end
    checks++;
    if (le_cnt !== 2 || le_gap !== 1600) begin
      failures++;
      $display("FAIL dflt_line_period got count=%0d gap=%0d exp count=2 gap=1600", le_cnt, le_gap);
    end
    checks++;
    if (hs_low !== 192) begin
      failures++;
      $display("FAIL dflt_hsync_width got=%0d exp=192", hs_low);
    end
  endtask

  task automatic test_pause();
    int guard = 0;
    int dx;
    int cx;
    bit dhs;
    while (!(cyc % 2 == 0 && (cyc / 2) % 8 == 3) && guard < 32) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 32 || a_x !== 3'd3 || a_pt !== 1'b1) begin
      failures++;
      $display("FAIL pause_entry got x=%0d pt=%b exp x=3 pt=1", a_x, a_pt);
    end
    dx  = cyc % 8;
    cx  = (cyc / 2) % 800;
    dhs = in_win(dx, 5, 2);
    en = 1'b0;
    repeat (7) begin
      step();
      checks++;
      if (a_x !== 3'd3 || {a_pt, a_vclk, a_le, a_fd, a_hs} !== 5'b00001) begin
        failures++;
        $display("FAIL pause_hold_a got x=%0d pt/vclk/le/fd/hs=%b exp x=3 00001", a_x, {a_pt, a_vclk, a_le, a_fd, a_hs});
      end
      checks++;
      if (int'(d_x) !== dx || d_pt !== 1'b0 || d_hs !== dhs || int'(c_x) !== cx || c_pt !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold_cd got dx=%0d dpt=%b dhs=%b cx=%0d cpt=%b exp dx=%0d dpt=0 dhs=%b cx=%0d cpt=0",
          d_x, d_pt, d_hs, c_x, c_pt, dx, dhs, cx);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (a_x !== 3'd3 || a_pt !== 1'b0 || a_vclk !== 1'b1 || int'(d_x) !== (dx + 1) % 8) begin
      failures++;
      $display("FAIL resume_first got ax=%0d pt=%b vclk=%b dx=%0d exp ax=3 pt=0 vclk=1 dx=%0d",
        a_x, a_pt, a_vclk, d_x, (dx + 1) % 8);
    end
    step();
    checks++;
    if (a_x !== 3'd4 || a_pt !== 1'b1) begin
      failures++;
      $display("FAIL resume_tick got x=%0d pt=%b exp x=4 pt=1", a_x, a_pt);
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] e;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    while (cyc < 44) step();
    checks++;
    if (a_x !== 3'd6 || a_y !== 3'd2 || b_bn !== 1'b1) begin
      failures++;
      $display("FAIL midframe_pos got x=%0d y=%0d b_bn=%b exp x=6 y=2 b_bn=1", a_x, a_y, b_bn);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({a_x, a_y} !== 6'd0 || {a_pt, a_bn, a_hs, a_vs, a_act} !== 5'b00111 || {b_x, b_bn, b_hs, b_vs} !== 6'b000011) begin
      failures++;
      $display("FAIL midframe_reset got ax=%0d ay=%0d a=%b bx=%0d b=%b exp 0 0 00111 0 011",
        a_x, a_y, {a_pt, a_bn, a_hs, a_vs, a_act}, b_x, {b_bn, b_hs, b_vs});
    end
    cyc = 0;
    repeat (10) begin
      step();
      e = exp_flags(cyc, 2, 3, 1'b0, 4, 1, 2, 1, 3, 1, 1, 1);
      checks++;
      if ({b_pt, b_vclk, b_le, b_fd, b_hs, b_vs, b_bn, b_act} !== e) begin
        failures++;
        $display("FAIL post_reset_delay cyc=%0d got=%b exp=%b", cyc, {b_pt, b_vclk, b_le, b_fd, b_hs, b_vs, b_bn, b_act}, e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_small_raster();
    test_pipe_delay();
    test_pol_div1();
    test_defaults();
    test_pause();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
